// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round-constant values and the GF(2^8) xtime helper.
// AES_KEY_SBOX_PIPE_EN (optional) selects the pipelined key schedule that uses COMPUTE.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    COMPUTE = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1B;
  localparam logic [3:0] AES_NR    = 4'd10;

  // Multiply by x in GF(2^8); also used by the column-mix stage.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
// Table is packed MSB-first so entry 0 sits at the top byte.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sbox
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n lives at bit offset (255-n)*8, and ~data equals 255-data.
  assign sbox = SBOX_TABLE[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expander streaming rk0..rk10 over a valid/ready handshake.
// Define AES_KEY_SBOX_PIPE_EN to register SubWord and insert a COMPUTE cycle per key.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  state_t state, state_d;

  logic [7:0]   rcon;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  sub_src;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] next_key;
  logic         load, advance, done_d;

  assign rot_word = {rk_out[23:0], rk_out[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data(rot_word[8*i +: 8]),
      .sbox(sub_word[8*i +: 8])
    );
  end

`ifdef AES_KEY_SBOX_PIPE_EN
  logic [31:0] sub_q;

  // Captured on the handshake edge; rk_out is stable through COMPUTE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= '0;
    end else if (state == PRESENT && rk_ready) begin
      sub_q <= sub_word;
    end
  end

  assign sub_src = sub_q;
`else
  assign sub_src = sub_word;
`endif

  assign w0n      = rk_out[127:96] ^ sub_src ^ {rcon, 24'h000000};
  assign w1n      = rk_out[95:64] ^ w0n;
  assign w2n      = rk_out[63:32] ^ w1n;
  assign w3n      = rk_out[31:0]  ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    advance  = 1'b0;
    done_d   = 1'b0;
    rk_valid = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        // The done cycle is treated as still finishing the previous run.
        if (start && !done) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (rk_idx == AES_NR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef AES_KEY_SBOX_PIPE_EN
            state_d = COMPUTE;
`else
            advance = 1'b1;
`endif
          end
        end
      end
`ifdef AES_KEY_SBOX_PIPE_EN
      COMPUTE: begin
        advance = 1'b1;
        state_d = PRESENT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out <= '0;
      rk_idx <= '0;
      rcon   <= RCON_INIT;
      done   <= 1'b0;
    end else begin
      done <= done_d;
      if (load) begin
        rk_out <= key_in;
        rk_idx <= '0;
        rcon   <= RCON_INIT;
      end else if (advance) begin
        rk_out <= next_key;
        rk_idx <= rk_idx + 4'd1;
        rcon   <= xtime(rcon);
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed vector bench for aes_key_schedule; expected round keys are FIPS-197 values.
// Timing expectations follow AES_KEY_SBOX_PIPE_EN when it is defined.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;

  int n_vec = 0;
  int n_err = 0;

`ifdef AES_KEY_SBOX_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam int MODE_NORMAL = 0;
  localparam int MODE_INJECT = 1;
  localparam int MODE_RESET  = 2;

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
    int           pct;
    int           mode;
  } vec_t;

  aes_key_schedule dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
    .rk_out  (rk_out),
    .rk_idx  (rk_idx),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int         exp_idx = 0;
    bit         finished = 0;
    bit         injected = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [127:0] prk = '0;
    logic [3:0] pidx = '0;

    @(negedge clk);
    start    = 1'b1;
    key_in   = v.key;
    rk_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};

    for (int k = 0; k < 400 && !finished; k++) begin
      if (pv && !pr) begin
        check("hold_valid", rk_valid, 1'b1);
        check("hold_key", rk_out, prk);
        check("hold_idx", rk_idx, pidx);
      end
      if (pv && pr) begin
        check("idx_order", pidx, exp_idx);
        if (pidx == 4'd0)  check("rk0", prk, v.key);
        if (pidx == 4'd1)  check("rk1", prk, v.rk1);
        if (pidx == 4'd10) check("rk10", prk, v.rk10);
        if (v.pct == 100) check("key_time", k - 1, exp_idx * STEP);
        if (pidx == 4'd10) begin
          check("done_pulse", done, 1'b1);
          check("busy_at_done", busy, 1'b0);
          if (v.pct == 100) check("done_time", k, 10 * STEP + 1);
          finished = 1;
        end else begin
          check("no_early_done", done, 1'b0);
        end
        exp_idx++;
      end
      if (v.pct == 100 && v.mode != MODE_RESET && k <= 10 * STEP)
        check("valid_shape", rk_valid, (k % STEP) == 0);

      if (v.mode == MODE_RESET && rk_valid && rk_idx == 4'd6) begin
        rst   = 1'b1;
        start = 1'b1;
        key_in = ~v.key;
        @(negedge clk);
        check("rst_rk_out", rk_out, '0);
        check("rst_rk_idx", rk_idx, '0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        rk_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("post_rst_idle", {done, busy, rk_valid}, 3'b000);
        end
        return;
      end

      if (v.mode == MODE_INJECT && !injected && rk_valid && rk_idx == 4'd4) begin
        start    = 1'b1;
        key_in   = ~v.key;
        injected = 1;
      end else begin
        start = 1'b0;
      end

      if (!finished) begin
        pv   = rk_valid;
        pr   = ($urandom_range(99) < v.pct);
        rk_ready = pr;
        prk  = rk_out;
        pidx = rk_idx;
        @(negedge clk);
      end
    end
    check("run_finished", finished, 1'b1);

    // Sitting in the done cycle: a start here must be ignored.
    start  = 1'b1;
    key_in = ~v.key;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("single_done", done, 1'b0);
    check("start_in_done_ignored", {busy, rk_valid}, 2'b00);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, MODE_NORMAL};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 100, MODE_NORMAL};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 100, MODE_NORMAL};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 30, MODE_NORMAL};
    vecs[4] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 30, MODE_NORMAL};
    vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, MODE_INJECT};
    vecs[6] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 100, MODE_NORMAL};
    vecs[7] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 30, MODE_RESET};
    vecs[8] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 100, MODE_NORMAL};

    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset_rk_out", rk_out, '0);
    check("reset_rk_idx", rk_idx, '0);
    check("reset_flags", {rk_valid, busy, done}, 3'b000);
    start = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < 9; i++) run(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
